multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle control unit for the 16-bit RISC core; the counterpart to the datapath's opcode/control-signal interface. It samples the 4-bit opcode from the datapath, sequences each instruction through fetch/decode/execute/memory/writeback states, and drives the register/ALU/memory/branch control lines plus PC and instruction-register write enables. It waits on a data-memory ready handshake and counts retired instructions.

## Interface
- RETIRE_W, 16, width of retired-instruction counter
- clk  in  1  system clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- opcode  in  4  instruction[15:12] from datapath, valid from DECODE onward
- mem_ready  in  1  data memory completed the current read/write this cycle
- reg_dst, alu_src, mem_to_reg, reg_w, mem_r, mem_w, beq, bne, j  out  1 each  datapath controls
- alu_op  out  2  00 = R-type (alucontrol decodes opcode), 01 = subtract/compare, 10 = add (address)
- ir_we  out  1  latch instruction register
- pc_we  out  1  load pc_next into PC (instruction retires)
- illegal  out  1  one-cycle pulse on undefined opcode
- retire_count  out  RETIRE_W  instructions retired since reset

## Operation
- Opcode map: 0000 LW, 0001 SW, 0010–1001 R-type ALU, 1011 BEQ, 1100 BNE, 1101 J; 1010, 1110, 1111 illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB. Opcode latched into op_q at end of DECODE; all outputs are Moore functions of (state, op_q), except DECODE, which uses the live opcode.
- IDLE: all outputs 0; next FETCH.
- FETCH: ir_we=1; next DECODE.
- DECODE: J → j=1, pc_we=1, next FETCH. Illegal → illegal=1, pc_we=1 (skip instruction), next FETCH. Otherwise next EXEC.
- EXEC: R-type: reg_dst=1, alu_src=0, alu_op=00, next WB. LW/SW: alu_src=1, alu_op=10, next MEM. BEQ/BNE: alu_op=01, beq or bne=1, pc_we=1, next FETCH.
- MEM: alu_src=1, alu_op=10, with mem_r=1 (LW) or mem_w=1 (SW) held every MEM cycle until mem_ready=1.
  - LW: on ready, next WB.
  - SW: on ready, pc_we=1 in that cycle, next FETCH.
  - Not ready: stay in MEM.
- WB: reg_w=1, pc_we=1.
  - R-type: reg_dst=1, mem_to_reg=0.
  - LW: reg_dst=0, mem_to_reg=1, alu_src=1, mem_r=1.
  - Next FETCH.
- mem_r and mem_w are never both 1. pc_we is 1 for exactly one cycle per instruction, including illegal instructions.
- retire_count increments by 1 on every cycle with pc_we=1 and wraps modulo 2^RETIRE_W (0xFFFF → 0x0000).

## Timing
- Reset: on a clk edge with rst=1, state becomes IDLE and retire_count becomes 0. From that edge, all control outputs read 0 and illegal reads 0. This holds from any state, including mid-MEM; an aborted store or load does not retire.
- First FETCH occurs the second edge after rst falls (IDLE for one cycle).
- Minimum latency in cycles, FETCH to FETCH: J / illegal 2; BEQ/BNE 3; R-type 4; SW 4; LW 5. Each cycle mem_ready is low in MEM adds 1.
- mem_ready is sampled only in MEM and ignored in all other states.
- The opcode input is ignored outside DECODE, so an opcode change after DECODE has no effect.

## Structure
- The shared package/include `isa_defs` holds:
  - opcode constants (OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, R-type range)
  - ALU_OP_RTYPE/SUB/ADD encodings
  - state encodings
- The datapath and alucontrol reuse the same `isa_defs`.
- Sub-module `opcode_classify` is combinational: opcode → {is_rtype, is_lw, is_sw, is_beq, is_bne, is_j, is_illegal}. It is instantiated once for the live opcode (DECODE) and once for op_q.
- Top level contains the state register, op_q register, output decode, and retire counter.

## Test plan
- Reset mid-MEM of SW with mem_ready=0 and rst pulsed 1 cycle → next cycle mem_w=0 and state IDLE; retire_count=0; FETCH with ir_we=1 two edges after rst falls.
- R-type opcode 0010 → cycles FETCH(ir_we), DECODE, EXEC(reg_dst=1, alu_op=00), WB(reg_w=1, reg_dst=1, pc_we=1); retire_count 0→1.
- LW (0000) with mem_ready low for 3 MEM cycles → mem_r=1 for 4 MEM cycles, then WB with mem_to_reg=1, reg_w=1, reg_dst=0; total 8 cycles.
- SW (0001) with mem_ready=1 immediately → exactly one MEM cycle with mem_w=1 and pc_we=1; reg_w never asserted.
- Sequence BEQ (1011), BNE (1100), J (1101), illegal (1110) → beq/bne asserted with alu_op=01 in EXEC; j=1 and pc_we=1 in DECODE; illegal=1 for one cycle in DECODE with pc_we=1; retire_count advances by 4.
- Preload retire_count at 0xFFFE via 2 retirements after forcing, or use RETIRE_W=2 with 4 J instructions → counter wraps to 0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// ----------------------------------------------------------------------------
// multicycle_control_pkg
// Purpose: ISA definitions shared by the control unit, the datapath and
//          alucontrol. Holds opcode constants, ALU-op encodings, control FSM
//          state encodings and the payload structs passed between blocks.
// Ports:   none (package).
// ----------------------------------------------------------------------------
package multicycle_control_pkg;

    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned ALU_OP_W = 2;
    localparam int unsigned STATE_W  = 3;

    // Opcode map (instruction[15:12])
    localparam logic [OPCODE_W-1:0] OP_LW       = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_SW       = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_RTYPE_LO = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_RTYPE_HI = 4'b1001;
    localparam logic [OPCODE_W-1:0] OP_BEQ      = 4'b1011;
    localparam logic [OPCODE_W-1:0] OP_BNE      = 4'b1100;
    localparam logic [OPCODE_W-1:0] OP_J        = 4'b1101;

    // ALU operation select
    localparam logic [ALU_OP_W-1:0] ALU_OP_RTYPE = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD   = 2'b10;

    // Control FSM states
    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_FETCH  = 3'd1;
    localparam logic [STATE_W-1:0] ST_DECODE = 3'd2;
    localparam logic [STATE_W-1:0] ST_EXEC   = 3'd3;
    localparam logic [STATE_W-1:0] ST_MEM    = 3'd4;
    localparam logic [STATE_W-1:0] ST_WB     = 3'd5;

    // One-hot instruction class of an opcode
    typedef struct packed {
        logic is_rtype;
        logic is_lw;
        logic is_sw;
        logic is_beq;
        logic is_bne;
        logic is_j;
        logic is_illegal;
    } op_class_t;

    // Datapath control word
    typedef struct packed {
        logic                reg_dst;
        logic                alu_src;
        logic                mem_to_reg;
        logic                reg_w;
        logic                mem_r;
        logic                mem_w;
        logic                beq;
        logic                bne;
        logic                j;
        logic [ALU_OP_W-1:0] alu_op;
        logic                ir_we;
        logic                pc_we;
        logic                illegal;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// ----------------------------------------------------------------------------
// multicycle_control_if
// Purpose: opcode/control-signal bundle between the control unit (master)
//          and the datapath (slave).
// Signals: opcode, mem_ready (datapath -> control);
//          reg_dst, alu_src, mem_to_reg, reg_w, mem_r, mem_w, beq, bne, j,
//          alu_op, ir_we, pc_we, illegal, retire_count (control -> datapath).
// ----------------------------------------------------------------------------
interface multicycle_control_if #(
    parameter int unsigned RETIRE_W = 16
);
    logic [3:0]          opcode;
    logic                mem_ready;
    logic                reg_dst;
    logic                alu_src;
    logic                mem_to_reg;
    logic                reg_w;
    logic                mem_r;
    logic                mem_w;
    logic                beq;
    logic                bne;
    logic                j;
    logic [1:0]          alu_op;
    logic                ir_we;
    logic                pc_we;
    logic                illegal;
    logic [RETIRE_W-1:0] retire_count;

    modport master (
        input  opcode, mem_ready,
        output reg_dst, alu_src, mem_to_reg, reg_w, mem_r, mem_w,
               beq, bne, j, alu_op, ir_we, pc_we, illegal, retire_count
    );

    modport slave (
        output opcode, mem_ready,
        input  reg_dst, alu_src, mem_to_reg, reg_w, mem_r, mem_w,
               beq, bne, j, alu_op, ir_we, pc_we, illegal, retire_count
    );
endinterface

// File: rtl/multicycle_control_opcode_classify.sv
// ----------------------------------------------------------------------------
// opcode_classify
// Purpose: combinational opcode -> one-hot instruction class.
// Ports:   i_opcode (4b opcode), o_class (op_class_t, exactly one bit set).
// ----------------------------------------------------------------------------
module opcode_classify
    import multicycle_control_pkg::*;
(
    input  logic [OPCODE_W-1:0] i_opcode,
    output op_class_t           o_class
);

    always_comb begin
        o_class = '0;
        if (i_opcode == OP_LW) begin
            o_class.is_lw = 1'b1;
        end else if (i_opcode == OP_SW) begin
            o_class.is_sw = 1'b1;
        end else if (i_opcode >= OP_RTYPE_LO && i_opcode <= OP_RTYPE_HI) begin
            o_class.is_rtype = 1'b1;
        end else if (i_opcode == OP_BEQ) begin
            o_class.is_beq = 1'b1;
        end else if (i_opcode == OP_BNE) begin
            o_class.is_bne = 1'b1;
        end else if (i_opcode == OP_J) begin
            o_class.is_j = 1'b1;
        end else begin
            o_class.is_illegal = 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
// Purpose: multi-cycle control FSM for the 16-bit RISC core. Sequences
//          FETCH/DECODE/EXEC/MEM/WB, drives datapath controls as Moore
//          outputs of (state, op_q) -- DECODE alone uses the live opcode --
//          and counts retired instructions (cycles with pc_we=1).
// Ports:   clk, rst (sync, active-high), bus (multicycle_control_if.master).
// ----------------------------------------------------------------------------
module multicycle_control #(
    parameter int unsigned RETIRE_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);
    import multicycle_control_pkg::*;

    logic [STATE_W-1:0]  r_state;
    logic [STATE_W-1:0]  w_next;
    logic [OPCODE_W-1:0] r_op_q;
    logic [RETIRE_W-1:0] r_retire;
    op_class_t           w_live;
    op_class_t           w_q;
    ctrl_t               w_ctrl;
    logic                w_live_exec;

    opcode_classify u_classify_live (.i_opcode(bus.opcode), .o_class(w_live));
    opcode_classify u_classify_q    (.i_opcode(r_op_q),     .o_class(w_q));

    assign w_live_exec = w_live.is_rtype | w_live.is_lw | w_live.is_sw |
                         w_live.is_beq   | w_live.is_bne;

    // State, latched opcode and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_op_q   <= '0;
            r_retire <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_op_q <= bus.opcode;
            end
            if (w_ctrl.pc_we) begin
                r_retire <= r_retire + RETIRE_W'(1);
            end
        end
    end

    // Next state and control decode
    always_comb begin
        w_next = r_state;
        w_ctrl = '0;
        case (r_state)
            ST_IDLE: begin
                w_next = ST_FETCH;
            end
            ST_FETCH: begin
                w_ctrl.ir_we = 1'b1;
                w_next       = ST_DECODE;
            end
            ST_DECODE: begin
                if (w_live.is_j) begin
                    w_ctrl.j     = 1'b1;
                    w_ctrl.pc_we = 1'b1;
                    w_next       = ST_FETCH;
                end else if (w_live.is_illegal || !w_live_exec) begin
                    // Skip the undefined instruction so it still retires once
                    w_ctrl.illegal = 1'b1;
                    w_ctrl.pc_we   = 1'b1;
                    w_next         = ST_FETCH;
                end else begin
                    w_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_q.is_rtype) begin
                    w_ctrl.reg_dst = 1'b1;
                    w_ctrl.alu_op  = ALU_OP_RTYPE;
                    w_next         = ST_WB;
                end else if (w_q.is_lw || w_q.is_sw) begin
                    w_ctrl.alu_src = 1'b1;
                    w_ctrl.alu_op  = ALU_OP_ADD;
                    w_next         = ST_MEM;
                end else if (w_q.is_beq || w_q.is_bne) begin
                    w_ctrl.alu_op = ALU_OP_SUB;
                    w_ctrl.beq    = w_q.is_beq;
                    w_ctrl.bne    = w_q.is_bne;
                    w_ctrl.pc_we  = 1'b1;
                    w_next        = ST_FETCH;
                end else begin
                    // Unreachable: op_q only holds opcodes that passed DECODE
                    w_ctrl.j       = w_q.is_j;
                    w_ctrl.illegal = w_q.is_illegal;
                    w_ctrl.pc_we   = 1'b1;
                    w_next         = ST_FETCH;
                end
            end
            ST_MEM: begin
                w_ctrl.alu_src = 1'b1;
                w_ctrl.alu_op  = ALU_OP_ADD;
                w_ctrl.mem_r   = w_q.is_lw;
                w_ctrl.mem_w   = !w_q.is_lw;
                if (bus.mem_ready) begin
                    if (w_q.is_lw) begin
                        w_next = ST_WB;
                    end else begin
                        w_ctrl.pc_we = 1'b1;
                        w_next       = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                w_ctrl.reg_w   = 1'b1;
                w_ctrl.pc_we   = 1'b1;
                w_ctrl.reg_dst = w_q.is_rtype;
                if (w_q.is_lw) begin
                    w_ctrl.mem_to_reg = 1'b1;
                    w_ctrl.alu_src    = 1'b1;
                    w_ctrl.mem_r      = 1'b1;
                end
                w_next = ST_FETCH;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign bus.reg_dst      = w_ctrl.reg_dst;
    assign bus.alu_src      = w_ctrl.alu_src;
    assign bus.mem_to_reg   = w_ctrl.mem_to_reg;
    assign bus.reg_w        = w_ctrl.reg_w;
    assign bus.mem_r        = w_ctrl.mem_r;
    assign bus.mem_w        = w_ctrl.mem_w;
    assign bus.beq          = w_ctrl.beq;
    assign bus.bne          = w_ctrl.bne;
    assign bus.j            = w_ctrl.j;
    assign bus.alu_op       = w_ctrl.alu_op;
    assign bus.ir_we        = w_ctrl.ir_we;
    assign bus.pc_we        = w_ctrl.pc_we;
    assign bus.illegal      = w_ctrl.illegal;
    assign bus.retire_count = r_retire;

endmodule

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control
// Purpose: self-checking bench. Two control units (16-bit and 2-bit retire
//          counters) share one stimulus stream. Each instruction is expanded
//          into its cycle-by-cycle list of expected control words; a single
//          negedge process compares both DUTs against that list and against
//          a running retirement total.
// ----------------------------------------------------------------------------
module tb_multicycle_control;

    // Bench-local control word: {reg_dst, alu_src, mem_to_reg, reg_w, mem_r,
    // mem_w, beq, bne, j, alu_op[1:0], ir_we, pc_we, illegal}
    localparam logic [13:0] C_REG_DST = 14'h2000;
    localparam logic [13:0] C_ALU_SRC = 14'h1000;
    localparam logic [13:0] C_M2R     = 14'h0800;
    localparam logic [13:0] C_REG_W   = 14'h0400;
    localparam logic [13:0] C_MEM_R   = 14'h0200;
    localparam logic [13:0] C_MEM_W   = 14'h0100;
    localparam logic [13:0] C_BEQ     = 14'h0080;
    localparam logic [13:0] C_BNE     = 14'h0040;
    localparam logic [13:0] C_J       = 14'h0020;
    localparam logic [13:0] C_AOP_ADD = 14'h0010;
    localparam logic [13:0] C_AOP_SUB = 14'h0008;
    localparam logic [13:0] C_IR_WE   = 14'h0004;
    localparam logic [13:0] C_PC_WE   = 14'h0002;
    localparam logic [13:0] C_ILL     = 14'h0001;

    logic       clk;
    logic       rst;
    logic [3:0] tb_op;
    logic       tb_mr;

    logic [13:0] exp_ctrl;
    logic        exp_valid;
    int          exp_r;
    int          m_retire;
    int          checks;
    int          failures;

    multicycle_control_if #(.RETIRE_W(16)) bus16 ();
    multicycle_control_if #(.RETIRE_W(2))  bus2  ();

    assign bus16.opcode    = tb_op;
    assign bus16.mem_ready = tb_mr;
    assign bus2.opcode     = tb_op;
    assign bus2.mem_ready  = tb_mr;

    multicycle_control #(.RETIRE_W(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
    multicycle_control #(.RETIRE_W(2))  u_dut2  (.clk(clk), .rst(rst), .bus(bus2));

    logic [13:0] act16;
    logic [13:0] act2;
    assign act16 = {bus16.reg_dst, bus16.alu_src, bus16.mem_to_reg, bus16.reg_w,
                    bus16.mem_r, bus16.mem_w, bus16.beq, bus16.bne, bus16.j,
                    bus16.alu_op, bus16.ir_we, bus16.pc_we, bus16.illegal};
    assign act2  = {bus2.reg_dst, bus2.alu_src, bus2.mem_to_reg, bus2.reg_w,
                    bus2.mem_r, bus2.mem_w, bus2.beq, bus2.bne, bus2.j,
                    bus2.alu_op, bus2.ir_we, bus2.pc_we, bus2.illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare process: outputs are checked mid-cycle
    always @(negedge clk) begin
        if (exp_valid) begin
            checks = checks + 4;
            if (act16 !== exp_ctrl) begin
                failures = failures + 1;
                $display("FAIL ctrl16 t=%0t got=%h want=%h", $time, act16, exp_ctrl);
            end
            if (act2 !== exp_ctrl) begin
                failures = failures + 1;
                $display("FAIL ctrl2 t=%0t got=%h want=%h", $time, act2, exp_ctrl);
            end
            if (bus16.retire_count !== 16'(exp_r)) begin
                failures = failures + 1;
                $display("FAIL retire16 t=%0t got=%0d want=%0d", $time, bus16.retire_count, 16'(exp_r));
            end
            if (bus2.retire_count !== 2'(exp_r)) begin
                failures = failures + 1;
                $display("FAIL retire2 t=%0t got=%0d want=%0d", $time, bus2.retire_count, 2'(exp_r));
            end
        end
    end

    // Hand-computed literal checks of the retire counters
    task automatic pin(input string name, input int got, input int want);
        checks = checks + 1;
        if (got != want) begin
            failures = failures + 1;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // One clock cycle: drive inputs and the expected control word, then advance
    task automatic cycle(input logic [3:0] op, input logic mr, input logic [13:0] e);
        rst       = 1'b0;
        tb_op     = op;
        tb_mr     = mr;
        exp_ctrl  = e;
        exp_valid = 1'b1;
        exp_r     = m_retire;
        if ((e & C_PC_WE) != 14'h0) m_retire = m_retire + 1;
        @(posedge clk);
        #1;
    endtask

    // One cycle with rst high; the outputs of that cycle still reflect the old state
    task automatic reset_cycle(input logic chk, input logic [13:0] e);
        rst       = 1'b1;
        tb_op     = 4'h0;
        tb_mr     = 1'b0;
        exp_ctrl  = e;
        exp_valid = chk;
        exp_r     = m_retire;
        @(posedge clk);
        #1;
        m_retire = 0;
    endtask

    // Expand one instruction into its expected cycle sequence
    task automatic run_instr(input logic [3:0] op, input int waits);
        logic [3:0]  jk;
        logic [13:0] agu;
        jk  = ~op;
        agu = C_ALU_SRC | C_AOP_ADD;
        cycle(jk, 1'b1, C_IR_WE);
        if (op == 4'b1101) begin
            cycle(op, 1'b1, C_J | C_PC_WE);
        end else if (op == 4'b1010 || op == 4'b1110 || op == 4'b1111) begin
            cycle(op, 1'b1, C_ILL | C_PC_WE);
        end else begin
            cycle(op, 1'b1, 14'h0);
            if (op == 4'b1011) begin
                cycle(jk, 1'b1, C_AOP_SUB | C_BEQ | C_PC_WE);
            end else if (op == 4'b1100) begin
                cycle(jk, 1'b1, C_AOP_SUB | C_BNE | C_PC_WE);
            end else if (op == 4'b0001) begin
                cycle(jk, 1'b1, agu);
                for (int k = 0; k < waits; k++) cycle(jk, 1'b0, agu | C_MEM_W);
                cycle(jk, 1'b1, agu | C_MEM_W | C_PC_WE);
            end else if (op == 4'b0000) begin
                cycle(jk, 1'b1, agu);
                for (int k = 0; k < waits; k++) cycle(jk, 1'b0, agu | C_MEM_R);
                cycle(jk, 1'b1, agu | C_MEM_R);
                cycle(jk, 1'b0, C_REG_W | C_M2R | C_ALU_SRC | C_MEM_R | C_PC_WE);
            end else begin
                cycle(jk, 1'b1, C_REG_DST);
                cycle(jk, 1'b0, C_REG_DST | C_REG_W | C_PC_WE);
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        m_retire  = 0;
        exp_valid = 1'b0;
        exp_ctrl  = '0;
        exp_r     = 0;
        rst       = 1'b1;
        tb_op     = 4'h0;
        tb_mr     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_cycle(1'b0, 14'h0);
        cycle(4'h5, 1'b1, 14'h0);                 // IDLE
        pin("reset_retire16", int'(bus16.retire_count), 0);

        // Store aborted by reset while waiting in MEM
        cycle(4'hE, 1'b1, C_IR_WE);
        cycle(4'h1, 1'b1, 14'h0);
        cycle(4'hE, 1'b1, C_ALU_SRC | C_AOP_ADD);
        cycle(4'hE, 1'b0, C_ALU_SRC | C_AOP_ADD | C_MEM_W);
        reset_cycle(1'b1, C_ALU_SRC | C_AOP_ADD | C_MEM_W);
        cycle(4'h1, 1'b1, 14'h0);                 // IDLE, mem_w dropped
        pin("abort_retire16", int'(bus16.retire_count), 0);
        pin("abort_retire2", int'(bus2.retire_count), 0);

        run_instr(4'b0010, 0);                     // R-type
        pin("rtype_retire16", int'(bus16.retire_count), 1);
        run_instr(4'b0000, 3);                     // LW, 3 wait cycles
        pin("lw_retire16", int'(bus16.retire_count), 2);
        run_instr(4'b0001, 0);                     // SW, ready at once
        pin("sw_retire16", int'(bus16.retire_count), 3);
        run_instr(4'b1011, 0);                     // BEQ
        run_instr(4'b1100, 0);                     // BNE
        run_instr(4'b1101, 0);                     // J
        run_instr(4'b1110, 0);                     // illegal
        pin("seq_retire16", int'(bus16.retire_count), 7);
        pin("seq_retire2", int'(bus2.retire_count), 3);
        run_instr(4'b1101, 0);                     // J: 2-bit counter wraps
        pin("wrap_retire2", int'(bus2.retire_count), 0);
        pin("wrap_retire16", int'(bus16.retire_count), 8);

        run_instr(4'b1001, 0);                     // last R-type opcode
        run_instr(4'b1010, 0);                     // illegal
        run_instr(4'b1111, 0);                     // illegal
        run_instr(4'b0001, 2);                     // SW, 2 wait cycles
        run_instr(4'b0000, 0);                     // LW, ready at once
        pin("end_retire16", int'(bus16.retire_count), 13);
        pin("end_retire2", int'(bus2.retire_count), 1);

        exp_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
